// File: rtl/ud_step_ctrl_if.sv
// ud_step_ctrl_if: control bus between ud_step_ctrl (master) and the up/down counter it drives.
interface ud_step_ctrl_if #(parameter int Data_width = 4);
  logic                  START;
  logic                  MODE;
  logic [Data_width-1:0] TARGET;
  logic                  ABORT;
  logic [Data_width-1:0] Q_FB;
  logic                  LD;
  logic                  UD;
  logic                  CE;
  logic [Data_width-1:0] D;
  logic                  BUSY;
  logic                  DONE;
  modport master (input START, MODE, TARGET, ABORT, Q_FB,
                  output LD, UD, CE, D, BUSY, DONE);
  modport slave  (output START, MODE, TARGET, ABORT, Q_FB,
                  input LD, UD, CE, D, BUSY, DONE);
endinterface

// File: rtl/ud_step_ctrl.sv
// ud_step_ctrl: steps or loads an up/down counter until its feedback equals a latched target.
module ud_step_ctrl #(
  parameter int Data_width = 4,
  parameter int Step_div   = 4
) (
  input logic CLK,
  input logic RST_N,
  ud_step_ctrl_if.master bus
);
  localparam int CW = $clog2(Step_div);
  typedef enum logic [2:0] {IDLE, COMPARE, STEP, WAIT, LOAD, FINISH} state_t;
  state_t state_q, state_d;
  logic ld_q, ld_d, ud_q, ud_d, ce_q, ce_d, done_q, done_d, busy_q, busy_d, abort;
  logic [Data_width-1:0] d_q, d_d, tgt_q, tgt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  assign abort = bus.ABORT && (state_q inside {COMPARE, STEP, WAIT, LOAD});
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      state_q <= IDLE;
      ld_q    <= 1'b0;
      ud_q    <= 1'b0;
      ce_q    <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      d_q     <= '0;
      tgt_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ld_q    <= ld_d;
      ud_q    <= ud_d;
      ce_q    <= ce_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      d_q     <= d_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
    end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.START) state_d = bus.MODE ? LOAD : COMPARE;
      COMPARE: state_d = (bus.Q_FB == tgt_q) ? FINISH : STEP;
      STEP:    state_d = WAIT;
      WAIT:    if (cnt_q == CW'(1)) state_d = COMPARE;
      LOAD:    state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end
  // Outputs are registered from the next state so they line up with the state they belong to.
  always_comb begin
    ld_d   = state_d == LOAD;
    ce_d   = state_d == STEP || state_d == LOAD;
    done_d = state_d == FINISH;
    busy_d = state_d != IDLE;
    ud_d   = (state_q == COMPARE && state_d == STEP) ? (tgt_q > bus.Q_FB) : ud_q;
    d_d    = (state_d == LOAD) ? bus.TARGET : d_q;
    tgt_d  = (state_q == IDLE && bus.START) ? bus.TARGET : tgt_q;
    cnt_d  = (state_q == STEP) ? CW'(Step_div - 1) : (state_q == WAIT) ? cnt_q - CW'(1) : cnt_q;
  end
  assign bus.LD   = ld_q;
  assign bus.UD   = ud_q;
  assign bus.CE   = ce_q;
  assign bus.D    = d_q;
  assign bus.BUSY = busy_q;
  assign bus.DONE = done_q;
endmodule

// File: doc/ud_step_ctrl.md
# ud_step_ctrl

Sequencer that drives an up/down counter's LD/UD/CE/D control inputs so that the counter's output reaches a requested target value. It sits beside the counter in the calculator datapath. It reads the counter value back on `Q_FB` and then does one of two things: issues single up- or down-steps at a programmable rate until the value equals the target, or performs a single-cycle parallel load. It is the initiator side of the counter's control interface and reports completion with a BUSY/DONE handshake.

## Interface
- `Data_width`, default 4: width of TARGET, Q_FB and D.
- `Step_div`, default 4: spacing between steps; legal values ≥ 2; step period is `Step_div+1` cycles.

- `CLK`  in  1  rising-edge clock.
- `RST_N`  in  1  asynchronous, active-low reset.
- `START`  in  1  request; sampled only in IDLE.
- `MODE`  in  1  0 = step toward TARGET; 1 = jump (parallel load); latched with START.
- `TARGET`  in  Data_width  destination value; latched with START.
- `ABORT`  in  1  cancel the current operation.
- `Q_FB`  in  Data_width  live counter output.
- `LD`  out  1  counter load enable (registered).
- `UD`  out  1  counter direction: 1 = up, 0 = down (registered).
- `CE`  out  1  counter clock enable (registered).
- `D`  out  Data_width  counter load data (registered).
- `BUSY`  out  1  high in every state except IDLE.
- `DONE`  out  1  one-cycle completion pulse.

## Operation
- **States:** IDLE, COMPARE, STEP, WAIT, LOAD, FINISH.
- **Reset:** RST_N low forces the following immediately and asynchronously:
  - state = IDLE;
  - LD = UD = CE = DONE = BUSY = 0;
  - D = 0; latched target = 0; wait counter = 0.
- **IDLE:**
  - START=1, MODE=0: latch TARGET, go to COMPARE.
  - START=1, MODE=1: latch TARGET, go to LOAD.
  - START=0: stay in IDLE.
- **COMPARE:** unsigned comparison of Q_FB against the latched target.
  - Equal: go to FINISH.
  - Target > Q_FB: go to STEP with UD=1.
  - Target < Q_FB: go to STEP with UD=0.
  - There is no wrap-around path: direction comes purely from the unsigned comparison.
- **STEP:** exactly one cycle, CE=1, LD=0. Then go to WAIT with the wait counter loaded to `Step_div-1`.
- **WAIT:** CE=0; decrement the wait counter each cycle; go to COMPARE when it reaches 0. This guarantees Q_FB has updated before the next compare.
- **LOAD:** exactly one cycle, LD=1, CE=1, D = latched target. Then go to FINISH. Q_FB is not checked afterwards.
- **FINISH:** DONE=1 for one cycle, then go to IDLE.
- **ABORT=1 in COMPARE, STEP, WAIT or LOAD:**
  - go to IDLE at the next edge;
  - LD and CE are 0 from that edge onward;
  - no DONE is produced.
- **ABORT in IDLE or FINISH:** ignored.
- **ABORT and START together in IDLE:** START wins.
- **START while BUSY:** ignored; TARGET and MODE changes while BUSY have no effect.
- **Q_FB changed externally mid-operation:** the next COMPARE re-evaluates and may reverse direction. The block steps indefinitely if Q_FB never reaches the target.
- **Output hold:** UD and D hold their last value outside STEP and LOAD. LD and CE are 0 in every state except STEP (CE only) and LOAD (both).

## Timing
- Cycle n denotes the cycle after edge n. START is sampled at edge 0.
- **Step mode:**
  - COMPARE in cycle 0.
  - If unequal: STEP in cycle 1 (CE high), counter updates at edge 2, WAIT in cycles 2..Step_div, COMPARE in cycle Step_div+1.
  - One CE pulse every `Step_div+1` cycles.
  - A run of N steps raises DONE in cycle `N*(Step_div+1)+1`, and BUSY falls at the edge ending that cycle.
- **Equal at start:** DONE in cycle 1; IDLE in cycle 2.
- **Jump mode:** LD = CE = 1 in cycle 0; DONE in cycle 1; IDLE in cycle 2.
- **Next request:** a new START is accepted in the first IDLE cycle after DONE.

## Test plan
All scenarios use Data_width=4 and Step_div=4.
- **Step up:** Q_FB=3 (model counter attached), START with MODE=0, TARGET=6 → 3 CE pulses with UD=1, spaced 5 cycles apart; LD never high; DONE in cycle 16; final Q=6.
- **Step down:** Q_FB=9, TARGET=2 → 7 CE pulses with UD=0; DONE in cycle 36; final Q=2.
- **Already equal:** Q_FB=5, TARGET=5 → no CE pulse; DONE in cycle 1; BUSY low from cycle 2.
- **Jump:** Q_FB=1, MODE=1, TARGET=0xC → single cycle with LD=CE=1 and D=0xC; DONE next cycle; counter reads 0xC.
- **Abort:** ABORT asserted in WAIT after the 2nd step of 3→9 → IDLE next edge; no DONE; exactly 2 CE pulses; Q=5.
- **Reset and busy START:** RST_N low mid-STEP → CE, BUSY and DONE go to 0 immediately; after release, a START pulsed while BUSY is ignored (no target change).
